// File: rtl/textmode_dspctl_pkg.sv
// ============================================================================
// Module : textmode_pkg
// Brief  : Shared types and constants for the text-mode display controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package textmode_pkg;

    localparam int c_rows_default = 30;
    localparam int c_cols_default = 80;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_SCROLL = 2'b10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        BUS_WR    = 3'd1,
        BUS_RD    = 3'd2,
        BUS_RDACK = 3'd3,
        ENG_RD    = 3'd4,
        ENG_WR    = 3'd5,
        ENG_FILL  = 3'd6,
        ENG_DONE  = 3'd7
    } state_t;

    // Scroll moves rows with a read/write pair; the bottom row (and clear) is a plain fill.
    function automatic state_t eng_first_state(input logic scroll, input logic is_last_row);
        return (scroll && !is_last_row) ? ENG_RD : ENG_FILL;
    endfunction

endpackage

`default_nettype wire

// File: rtl/textmode_dspctl_if.sv
// ============================================================================
// Module : textmode_dspctl_if
// Brief  : Bus slave handshake between a CPU-side master and the controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface textmode_dspctl_if;
    logic        bus_stb;
    logic        bus_we;
    logic [11:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_ack;

    modport master (output bus_stb, bus_we, bus_addr, bus_wdata,
                    input  bus_rdata, bus_ack);
    modport slave  (input  bus_stb, bus_we, bus_addr, bus_wdata,
                    output bus_rdata, bus_ack);
endinterface

`default_nettype wire

// File: rtl/textmode_dspctl_walker.sv
// ============================================================================
// Module : textmode_dspctl_walker
// Brief  : Row/column cell counter, column-fastest, with last-cell flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module textmode_dspctl_walker #(
    parameter int ROWS = 30,
    parameter int COLS = 80
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       load,
    input  wire logic       step,
    output logic [4:0]      row,
    output logic [6:0]      col,
    output logic [4:0]      nxt_row,
    output logic [6:0]      nxt_col,
    output logic            last
);
    localparam logic [4:0] c_last_row = 5'(ROWS - 1);
    localparam logic [6:0] c_last_col = 7'(COLS - 1);

    logic [4:0] r_row;
    logic [6:0] r_col;

    always_comb begin
        nxt_row = r_row;
        nxt_col = r_col + 7'd1;
        if (r_col == c_last_col) begin
            nxt_col = 7'd0;
            nxt_row = r_row + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= 5'd0;
            r_col <= 7'd0;
        end else if (load) begin
            r_row <= 5'd0;
            r_col <= 7'd0;
        end else if (step) begin
            r_row <= nxt_row;
            r_col <= nxt_col;
        end
    end

    assign row  = r_row;
    assign col  = r_col;
    assign last = (r_row == c_last_row) && (r_col == c_last_col);

endmodule

`default_nettype wire

// File: rtl/textmode_dspctl.sv
// ============================================================================
// Module : textmode_dspctl
// Brief  : Display-memory port-A arbiter: bus slave plus clear/scroll engine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module textmode_dspctl
    import textmode_pkg::*;
#(
    parameter int ROWS = c_rows_default,
    parameter int COLS = c_cols_default
) (
    input  wire logic         clk,
    input  wire logic         rst,
    textmode_dspctl_if.slave  bus,
    input  wire logic         cmd_valid,
    input  wire logic [1:0]   cmd_op,
    input  wire logic [15:0]  cmd_fill,
    output logic              cmd_ready,
    output logic              busy,
    output logic              done,
    output logic [4:0]        mem_row,
    output logic [6:0]        mem_col,
    output logic [15:0]       mem_wdata,
    input  wire logic [15:0]  mem_rdata,
    output logic              mem_en,
    output logic              mem_wr
);
    localparam logic [4:0] c_last_row = 5'(ROWS - 1);

    state_t      r_state, w_nxt, w_eng_first, w_bus_state;
    logic        r_busy, r_scroll, r_wsel, r_ack, r_ack_rd, r_done, r_ready;
    logic        r_mem_en, r_mem_wr;
    logic [4:0]  r_mem_row;
    logic [6:0]  r_mem_col;
    logic [15:0] r_mem_wdata, r_fill;

    logic        w_load, w_step, w_last, w_idle, w_boundary, w_eng_scroll, w_cmd_go;
    logic [4:0]  w_row, w_nxt_row, w_eng_row;
    logic [6:0]  w_col, w_nxt_col, w_eng_col;

    textmode_dspctl_walker #(.ROWS(ROWS), .COLS(COLS)) u_walker (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .step    (w_step),
        .row     (w_row),
        .col     (w_col),
        .nxt_row (w_nxt_row),
        .nxt_col (w_nxt_col),
        .last    (w_last)
    );

    // Cell the engine would issue next: origin on accept, the stepped cell at a
    // boundary, or the held cell when resuming after a bus access.
    assign w_idle       = (r_state == IDLE) || (r_state == ENG_DONE);
    assign w_boundary   = (r_state == ENG_WR) || (r_state == ENG_FILL);
    assign w_eng_row    = w_idle ? 5'd0 : (w_boundary ? w_nxt_row : w_row);
    assign w_eng_col    = w_idle ? 7'd0 : (w_boundary ? w_nxt_col : w_col);
    assign w_eng_scroll = w_idle ? (cmd_op == OP_SCROLL) : r_scroll;
    assign w_eng_first  = eng_first_state(w_eng_scroll, w_eng_row == c_last_row);
    assign w_bus_state  = bus.bus_we ? BUS_WR : BUS_RD;
    assign w_cmd_go     = cmd_valid && ((cmd_op == OP_CLEAR) || (cmd_op == OP_SCROLL));

    always_comb begin
        w_nxt  = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        case (r_state)
            IDLE, ENG_DONE: begin
                if (bus.bus_stb) begin
                    w_nxt = w_bus_state;
                end else if (w_cmd_go) begin
                    w_load = 1'b1;
                    w_nxt  = w_eng_first;
                end else begin
                    w_nxt = IDLE;
                end
            end
            BUS_WR, BUS_RDACK: w_nxt = r_busy ? w_eng_first : IDLE;
            BUS_RD:            w_nxt = BUS_RDACK;
            ENG_RD:            w_nxt = ENG_WR;
            ENG_WR, ENG_FILL: begin
                if (w_last) begin
                    w_nxt = ENG_DONE;
                end else begin
                    w_step = 1'b1;
                    w_nxt  = bus.bus_stb ? w_bus_state : w_eng_first;
                end
            end
            default:           w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_scroll    <= 1'b0;
            r_fill      <= 16'h0;
            r_wsel      <= 1'b0;
            r_ack       <= 1'b0;
            r_ack_rd    <= 1'b0;
            r_done      <= 1'b0;
            r_ready     <= 1'b1;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_row   <= 5'd0;
            r_mem_col   <= 7'd0;
            r_mem_wdata <= 16'h0;
        end else begin
            r_state  <= w_nxt;
            r_ready  <= (w_nxt == IDLE) || (w_nxt == ENG_DONE);
            r_mem_en <= 1'b0;
            r_mem_wr <= 1'b0;
            r_wsel   <= 1'b0;
            r_ack    <= 1'b0;
            r_ack_rd <= 1'b0;
            r_done   <= 1'b0;
            if (w_load) begin
                r_fill   <= cmd_fill;
                r_scroll <= (cmd_op == OP_SCROLL);
                r_busy   <= 1'b1;
            end
            case (w_nxt)
                BUS_WR: begin
                    r_mem_en    <= 1'b1;
                    r_mem_wr    <= 1'b1;
                    r_mem_row   <= bus.bus_addr[11:7];
                    r_mem_col   <= bus.bus_addr[6:0];
                    r_mem_wdata <= bus.bus_wdata;
                    r_ack       <= 1'b1;
                end
                BUS_RD: begin
                    r_mem_en  <= 1'b1;
                    r_mem_row <= bus.bus_addr[11:7];
                    r_mem_col <= bus.bus_addr[6:0];
                end
                BUS_RDACK: begin
                    r_ack    <= 1'b1;
                    r_ack_rd <= 1'b1;
                end
                ENG_RD: begin
                    r_mem_en  <= 1'b1;
                    r_mem_row <= w_eng_row + 5'd1;
                    r_mem_col <= w_eng_col;
                end
                ENG_WR: begin
                    r_mem_en  <= 1'b1;
                    r_mem_wr  <= 1'b1;
                    r_mem_row <= w_row;
                    r_mem_col <= w_col;
                    r_wsel    <= 1'b1;
                end
                ENG_FILL: begin
                    r_mem_en    <= 1'b1;
                    r_mem_wr    <= 1'b1;
                    r_mem_row   <= w_eng_row;
                    r_mem_col   <= w_eng_col;
                    r_mem_wdata <= w_idle ? cmd_fill : r_fill;
                end
                ENG_DONE: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Read data only exists in the cycle after the read, so the scroll write and
    // the bus read data are steered straight from the memory port.
    assign mem_wdata     = r_wsel ? mem_rdata : r_mem_wdata;
    assign bus.bus_rdata = r_ack_rd ? mem_rdata : 16'h0;
    assign bus.bus_ack   = r_ack;
    assign mem_en        = r_mem_en;
    assign mem_wr        = r_mem_wr;
    assign mem_row       = r_mem_row;
    assign mem_col       = r_mem_col;
    assign busy          = r_busy;
    assign done          = r_done;
    assign cmd_ready     = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_textmode_dspctl.sv
// ============================================================================
// Module : tb_textmode_dspctl
// Brief  : Directed self-checking bench with a 32x128 synchronous memory model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_textmode_dspctl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] cmd_fill = 16'h0;
    logic        cmd_ready, busy, done, mem_en, mem_wr;
    logic [4:0]  mem_row;
    logic [6:0]  mem_col;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rd = 16'h0;
    logic [15:0] mem [0:4095];

    int total = 0;
    int bad   = 0;

    textmode_dspctl_if bif ();

    textmode_dspctl #(.ROWS(30), .COLS(80)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bif),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_fill  (cmd_fill),
        .cmd_ready (cmd_ready),
        .busy      (busy),
        .done      (done),
        .mem_row   (mem_row),
        .mem_col   (mem_col),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rd),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wr) mem[{mem_row, mem_col}] <= mem_wdata;
            else        mem_rd <= mem[{mem_row, mem_col}];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [11:0] addr, input logic [15:0] data);
        bif.bus_stb = 1'b1; bif.bus_we = 1'b1; bif.bus_addr = addr; bif.bus_wdata = data;
        tick();
        bif.bus_stb = 1'b0;
        tick();
    endtask

    task automatic bus_read(input logic [11:0] addr, output logic ack, output logic [15:0] data);
        bif.bus_stb = 1'b1; bif.bus_we = 1'b0; bif.bus_addr = addr;
        tick();
        bif.bus_stb = 1'b0;
        tick();
        ack  = bif.bus_ack;
        data = bif.bus_rdata;
        tick();
    endtask

    task automatic preload();
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                bus_write({5'(r), 7'(c)}, 16'(r * 16'h0101));
        bus_write({5'd31, 7'd0}, 16'hBEEF);
    endtask

    // Issues a command, optionally raises a bus read of (31,0) at cycle stb_at,
    // and runs until done; cycles counts edges from the accept edge to done.
    task automatic run_op(input logic [1:0] op, input logic [15:0] fill, input int stb_at,
                          output int cycles, output int writes, output int pair_err,
                          output logic [15:0] rd, output int ack_lat);
        bit         rd_pend = 0;
        logic [4:0] prow = 5'd0;
        cycles = 0; writes = 0; pair_err = 0; rd = 16'h0; ack_lat = -1;
        cmd_valid = 1'b1; cmd_op = op; cmd_fill = fill;
        while (!done && cycles < 20000) begin
            if (cycles == stb_at) begin
                bif.bus_stb = 1'b1; bif.bus_we = 1'b0; bif.bus_addr = {5'd31, 7'd0};
            end
            tick();
            cmd_valid = 1'b0;
            cycles++;
            if (rd_pend) begin
                if (!(mem_en && mem_wr && mem_row == prow - 5'd1)) pair_err++;
                rd_pend = 0;
            end
            if (mem_en && !mem_wr && mem_row != 5'd31) begin
                rd_pend = 1;
                prow    = mem_row;
            end
            if (mem_en && mem_wr) writes++;
            if (bif.bus_ack && bif.bus_stb) begin
                rd          = bif.bus_rdata;
                ack_lat     = cycles - stb_at;
                bif.bus_stb = 1'b0;
            end
        end
    endtask

    initial begin
        int          cyc, wr, perr, lat, errs, act;
        logic        ack;
        logic [15:0] rd, exp;
        bif.bus_stb = 1'b0; bif.bus_we = 1'b0; bif.bus_addr = 12'h0; bif.bus_wdata = 16'h0;

        repeat (3) tick();
        check("reset_state", {bif.bus_ack, bif.bus_rdata, busy, done, cmd_ready, mem_en, mem_wr,
                              mem_row, mem_col, mem_wdata},
              {1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 7'd0, 16'h0});
        rst = 1'b0;
        tick();

        // Bus write then read of (3,5)
        bif.bus_stb = 1'b1; bif.bus_we = 1'b1; bif.bus_addr = {5'd3, 7'd5}; bif.bus_wdata = 16'h1E41;
        tick();
        check("wr_issue", {mem_en, mem_wr, mem_row, mem_col, mem_wdata, bif.bus_ack},
              {1'b1, 1'b1, 5'd3, 7'd5, 16'h1E41, 1'b1});
        bif.bus_stb = 1'b0;
        tick();
        check("wr_ack_one_cycle", {bif.bus_ack, mem_en}, 2'b00);
        bif.bus_stb = 1'b1; bif.bus_we = 1'b0;
        tick();
        check("rd_issue", {bif.bus_ack, mem_en, mem_wr, mem_row, mem_col},
              {1'b0, 1'b1, 1'b0, 5'd3, 7'd5});
        bif.bus_stb = 1'b0;
        tick();
        check("rd_ack", {bif.bus_ack, bif.bus_rdata}, {1'b1, 16'h1E41});
        tick();
        check("rd_ack_one_cycle", bif.bus_ack, 1'b0);

        // Clear screen
        run_op(2'b01, 16'h0720, -1, cyc, wr, perr, rd, lat);
        check("clear_done_cycle", cyc, 2401);
        check("clear_writes", wr, 2400);
        check("clear_done_flags", {busy, cmd_ready}, 2'b01);
        tick();
        bus_read({5'd0, 7'd0}, ack, rd);   check("clear_cell_0_0",   {ack, rd}, {1'b1, 16'h0720});
        bus_read({5'd29, 7'd79}, ack, rd); check("clear_cell_29_79", {ack, rd}, {1'b1, 16'h0720});
        bus_read({5'd15, 7'd40}, ack, rd); check("clear_cell_15_40", {ack, rd}, {1'b1, 16'h0720});

        // Scroll without bus traffic
        preload();
        run_op(2'b10, 16'h0700, -1, cyc, wr, perr, rd, lat);
        check("scroll_done_cycle", cyc, 4721);
        check("scroll_pairs", perr, 0);
        tick();
        errs = 0;
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++) begin
                exp = (r == 29) ? 16'h0700 : 16'((r + 1) * 16'h0101);
                if (mem[{5'(r), 7'(c)}] !== exp) errs++;
            end
        check("scroll_contents", errs, 0);
        bus_read({5'd28, 7'd3}, ack, rd); check("scroll_cell_28_3", {ack, rd}, {1'b1, 16'h1D1D});

        // Scroll with a bus read injected mid-operation
        preload();
        run_op(2'b10, 16'h0700, 101, cyc, wr, perr, rd, lat);
        check("midscroll_rdata", rd, 16'hBEEF);
        check("midscroll_ack_latency", (lat >= 2 && lat <= 3), 1'b1);
        check("midscroll_done_cycle", cyc, 4723);
        check("midscroll_pairs", perr, 0);
        tick();
        errs = 0;
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++) begin
                exp = (r == 29) ? 16'h0700 : 16'((r + 1) * 16'h0101);
                if (mem[{5'(r), 7'(c)}] !== exp) errs++;
            end
        check("midscroll_contents", errs, 0);

        // Reset in the middle of a clear
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_fill = 16'h1111;
        tick();
        cmd_valid = 1'b0;
        repeat (999) tick();
        rst = 1'b1;
        #1;
        check("midclear_reset", {bif.bus_ack, bif.bus_rdata, busy, done, cmd_ready, mem_en, mem_wr,
                                 mem_row, mem_col, mem_wdata},
              {1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 7'd0, 16'h0});
        tick();
        rst = 1'b0;
        act = 0;
        repeat (20) begin
            tick();
            if (mem_en || busy || done) act++;
        end
        check("post_reset_quiet", act, 0);
        run_op(2'b01, 16'h0720, -1, cyc, wr, perr, rd, lat);
        check("reclear_done_cycle", cyc, 2401);
        tick();
        check("reclear_cell_29_79", mem[{5'd29, 7'd79}], 16'h0720);

        // No-op commands
        act = 0;
        cmd_valid = 1'b1; cmd_op = 2'b00;
        repeat (4) begin tick(); if (mem_en || busy || done || !cmd_ready) act++; end
        cmd_op = 2'b11;
        repeat (4) begin tick(); if (mem_en || busy || done || !cmd_ready) act++; end
        cmd_valid = 1'b0;
        tick();
        check("nop_no_activity", act, 0);

        // Bus and command together: bus first, command accepted back in IDLE
        bif.bus_stb = 1'b1; bif.bus_we = 1'b1; bif.bus_addr = {5'd2, 7'd2}; bif.bus_wdata = 16'h1234;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_fill = 16'h5A5A;
        tick();
        check("both_bus_first", {bif.bus_ack, busy, cmd_ready}, 3'b100);
        bif.bus_stb = 1'b0;
        tick();
        check("both_pending_ready", {busy, cmd_ready}, 2'b01);
        tick();
        check("both_accepted", {busy, cmd_ready, mem_en}, 3'b101);
        cmd_valid = 1'b0;
        repeat (2400) tick();
        check("both_done", {done, busy}, 2'b10);
        check("both_cell_2_2", mem[{5'd2, 7'd2}], 16'h5A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/textmode_dspctl.md
Name: textmode_dspctl

Overview:
Port-A controller for the text-mode display memory (32x128 cells, 16-bit {attr,char}, 1-cycle synchronous read). Shares the single read/write port between a bus slave interface and an internal fill/scroll engine. The engine implements "clear screen" and "scroll up one line" in hardware. The refresh port is not touched by this block.

Parameters:
ROWS, 30, visible text rows (1..32)
COLS, 80, visible text columns (1..128)

Ports:
clk  in  1  system clock (same clock as display memory port A)
rst  in  1  asynchronous, active-high reset
bus_stb  in  1  bus request strobe
bus_we  in  1  1 = write, 0 = read
bus_addr  in  12  {row[4:0], col[6:0]}
bus_wdata  in  16  write data {attr,char}
bus_rdata  out  16  read data, valid while bus_ack=1
bus_ack  out  1  single-cycle acknowledge
cmd_valid  in  1  engine command request
cmd_op  in  2  01 = clear, 10 = scroll up; 00/11 = no-op
cmd_fill  in  16  fill cell value for clear / vacated last row
cmd_ready  out  1  engine idle, command accepted when valid&ready
busy  out  1  engine operation in progress
done  out  1  one-cycle pulse after the engine's final write
mem_row  out  5  display memory row address
mem_col  out  7  display memory column address
mem_wdata  out  16  display memory write data
mem_rdata  in  16  display memory read data
mem_en  out  1  display memory enable
mem_wr  out  1  display memory write enable

Behaviour:
- Reset (async, rst=1): state IDLE; bus_ack=0, bus_rdata=0, busy=0, done=0, cmd_ready=1, mem_en=0, mem_wr=0, mem_row/col/wdata=0. Reset mid-operation abandons it; memory is left partially modified.
- All mem_* outputs are registered. mem_en=0 whenever no access is issued.
- States: IDLE, BUS_WR, BUS_RD, BUS_RDACK, ENG_RD, ENG_WR, ENG_FILL, ENG_DONE.
- Bus write: stb seen in cycle N (state IDLE or at an engine cell boundary) -> cycle N+1: mem_en=mem_wr=1 at bus_addr with bus_wdata, and bus_ack=1.
- Bus read: cycle N+1 mem_en=1, mem_wr=0; cycle N+2 bus_ack=1, bus_rdata=mem_rdata.
- bus_ack lasts exactly one cycle. A stb still high in the cycle after ack is treated as a new request. bus_addr is passed through unchecked (out-of-range rows/cols are legal memory cells).
- Command accept: cmd_valid & cmd_ready in IDLE with op 01/10 -> busy=1 and cmd_ready=0 next cycle. cmd_fill is latched at accept. Ops 00/11 are consumed with no effect and no done pulse.
- Clear: ENG_FILL writes the latched fill to (r,c) for r=0..ROWS-1, c=0..COLS-1, column-fastest, one cell per cycle.
- Scroll: for r=0..ROWS-2, each c in turn:
  - ENG_RD reads (r+1,c).
  - ENG_WR writes mem_rdata to (r,c) in the next cycle.
  - Then ENG_FILL writes the fill to row ROWS-1.
- ENG_DONE: done=1 for one cycle, busy=0, cmd_ready=1, return to IDLE.
- Arbitration: the bus has priority, but only at cell boundaries (never between ENG_RD and its ENG_WR). After the bus access completes, the engine resumes at the next cell. Bus writes to cells not yet processed during a scroll are legal; their result is undefined by design.
- Simultaneous bus_stb and cmd_valid in IDLE: the bus is served first. The command stays pending (cmd_ready=1 remains asserted only in IDLE) and is accepted on return to IDLE.
- Cycle counts with no bus traffic:
  - Clear: ROWS*COLS write cycles.
  - Scroll: 2*(ROWS-1)*COLS + COLS cycles.
  - Both are followed by the done cycle.
- Counter wrap: col wraps COLS-1 -> 0 with row+1. The last cell detected is (ROWS-1, COLS-1).

Decomposition:
- Shared package textmode_pkg: ROWS/COLS defaults, cmd_op encodings (OP_NOP, OP_CLEAR, OP_SCROLL), state encoding.
- One sub-module, textmode_dspctl_walker: the row/col cell counter with load, step, COLS wrap and last-cell flag.

Test Plan:
- Reset, then bus write 0x1E41 to row 3 col 5 -> mem_wr pulse at addr {3,5} one cycle after stb, with ack in the same cycle; a read of the same address -> ack 2 cycles after stb, bus_rdata=0x1E41.
- Clear with fill 0x0720 (ROWS=30, COLS=80) -> busy for 2400 write cycles, done pulse at cycle 2401; sampled cells (0,0), (29,79) and (15,40) read 0x0720.
- Preload row r with value r*0x0101, scroll with fill 0x0700 -> rows 0..28 hold (r+1)*0x0101, row 29 holds 0x0700; done after 4720 cycles.
- Bus read issued mid-scroll -> ack within 3 cycles of the next cell boundary, never splitting a read/write pair; total scroll time grows by exactly the bus cycles consumed.
- Assert rst during a clear at cell 1000 -> all outputs are 0 immediately, busy=0 and no done pulse; a new clear afterwards completes normally.
- cmd_op=00 and 11 with cmd_valid -> no mem_en activity, busy remains 0, no done pulse.
